ctrl_redirect_sched: RTL and testbench
======================================

# ctrl_redirect_sched

Sequential scheduler between the control-ALU lanes of the execute stage and the fetch/recovery logic. Each cycle it collects resolved control instructions (branch, JAL/JALR, FENCE.I) from all control lanes and keeps the single oldest mispredict. It issues that mispredict as one redirect to fetch over a valid/ready handshake, then runs a fixed-length recovery window. During recovery it asserts squash and blocks further control issue.

## Interface
Parameters:
- `NUM_LANES`, 2, number of control-ALU lanes feeding the block
- `AL_ID_W`, 7, ActiveList index width (`SIZE_ACTIVELIST_LOG`)
- `PC_W`, 32, PC width (`SIZE_PC`)
- `RECOVER_CYCLES`, 2, length of the recovery window in cycles (≥1)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `lane_valid_i` in NUM_LANES: lane carries a resolved control op this cycle
- `lane_mispred_i` in NUM_LANES: `flags.mispredict` from that lane's control ALU
- `lane_alId_i` in NUM_LANES×AL_ID_W: ActiveList id of the lane's op
- `lane_nextPC_i` in NUM_LANES×PC_W: resolved next PC from the control ALU
- `alHead_i` in AL_ID_W: current ActiveList head (oldest in-flight id)
- `redirect_valid_o` out 1: redirect offered to fetch
- `redirect_ready_i` in 1: fetch accepts the redirect
- `redirect_pc_o` out PC_W: target PC of the offered redirect
- `redirect_alId_o` out AL_ID_W: ActiveList id of the redirecting op
- `recover_o` out 1: squash younger-than-`redirect_alId_o` state
- `stall_ctrl_o` out 1: blocks issue of new control ops

## Operation
- Age: `age(id) = (id − alHead_i) mod 2^AL_ID_W`. A smaller age is older. Age is always computed against the current `alHead_i`, including for the stored pending entry.
- Candidate: a lane with `lane_valid_i & lane_mispred_i`. The cycle winner is the oldest candidate. On equal ids, the lower lane index wins.
- Pending slot `{pvalid, pId, pPC}`:
  - It captures the cycle winner if the slot is empty, or if the winner is strictly older than `pId`.
  - A younger or equal winner is dropped.
- FSM states and transitions:
  - IDLE: go to PEND when a winner exists.
  - PEND: `redirect_valid_o=1`, with the payload taken from the pending slot.
    - On `valid&ready` the slot is consumed and the FSM goes to RECOVER with counter = RECOVER_CYCLES.
    - The payload may change while unaccepted, but only to an older op.
    - Fetch samples the payload only on the handshake cycle.
  - RECOVER: `recover_o=1`; the counter decrements each cycle. At counter==1:
    - go to PEND if `pvalid`,
    - otherwise go to IDLE.
  - Winners arriving during RECOVER are captured into the slot only if older than the `redirect_alId_o` in recovery. Younger winners are squashed and ignored.
- Simultaneous handshake and new older winner: the transfer completes, the new winner fills the slot, and the FSM returns to PEND after RECOVER.
- `stall_ctrl_o = (state != IDLE)`.
- Non-mispredicting lanes never change state.

## Timing
- Reset values: state IDLE, slot empty, counter 0. All outputs are 0: `redirect_valid_o`, `redirect_pc_o`, `redirect_alId_o`, `recover_o`, `stall_ctrl_o`.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency:
  - A mispredict at cycle t gives `redirect_valid_o` and `stall_ctrl_o` high at t+1.
  - A handshake at T gives `recover_o` high on T+1 … T+RECOVER_CYCLES.
  - The FSM reaches IDLE (or PEND) at T+RECOVER_CYCLES+1.
- Backpressure: `redirect_valid_o` stays high indefinitely while `redirect_ready_i=0`. There is no timeout.
- Wrap-around: `alHead_i` near 2^AL_ID_W−1 with ids wrapping to 0 must order correctly via the modular age.
- Reset mid-PEND or mid-RECOVER drops the pending redirect. Outputs go to 0 asynchronously.

## Structure
- Shared package holds:
  - the `redirectPkt` typedef `{pc, alId}`,
  - the FSM state enum `{IDLE, PEND, RECOVER}`,
  - the `ageOf(id, head)` function.
- One sub-module, `ctrl_age_select`: combinational oldest-of-N selection returning winner valid, id, and PC. The top holds the slot, the FSM and the counter.

## Test plan
- Lane0 mispredict, id 5, PC 0x1000, head 0, ready=1 → `redirect_valid_o` at t+1 with PC 0x1000 and alId 5. `recover_o` high for 2 cycles, then IDLE.
- Same cycle: lane0 id 9 and lane1 id 4, both mispredicting, head 2 → redirect alId 4, lane1's PC.
- Head 126; lane0 id 1 in cycle t, lane1 id 127 in cycle t+1, ready=0 until t+3 → payload switches to id 127 at t+2 and the handshake carries 127.
- During RECOVER for id 20: mispredict id 30 arrives → ignored, IDLE after window. A mispredict id 15 arrives instead → PEND with alId 15 immediately after the window.
- Assert reset during PEND with ready=0 → all outputs 0 before the next edge. After release, the FSM stays IDLE with no input.
- `lane_valid_i=1`, `lane_mispred_i=0` on all lanes for 100 cycles → outputs stay 0.

Source files
------------

// File: rtl/ctrl_redirect_sched_pkg.sv
// Shared types and helpers for the control redirect scheduler:
// redirect payload, FSM states and ActiveList age arithmetic.
package ctrl_redirect_sched_pkg;

    localparam int CRS_AL_ID_W = 7;
    localparam int CRS_PC_W    = 32;

    typedef struct packed {
        logic [CRS_PC_W-1:0]    pc;
        logic [CRS_AL_ID_W-1:0] alId;
    } redirectPkt;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RECOVER = 2'd2
    } redirect_state_e;

    // Distance of id from the ActiveList head, modulo 2^w.
    // Smaller means older; wraps correctly around the top of the list.
    function automatic logic [31:0] ageOf(
        input logic [31:0] id,
        input logic [31:0] head,
        input int          w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (id - head) & mask;
    endfunction

endpackage

// File: rtl/ctrl_redirect_sched_age_select.sv
// Combinational oldest-of-N pick among mispredicting control lanes.
// Ties on age resolve to the lowest lane index.
module ctrl_age_select
    import ctrl_redirect_sched_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int AL_ID_W   = 7,
    parameter int PC_W      = 32
) (
    input  logic [NUM_LANES-1:0]         cand_i,
    input  logic [NUM_LANES*AL_ID_W-1:0] id_i,
    input  logic [NUM_LANES*PC_W-1:0]    pc_i,
    input  logic [AL_ID_W-1:0]           head_i,
    output logic                         win_valid_o,
    output logic [AL_ID_W-1:0]           win_id_o,
    output logic [PC_W-1:0]              win_pc_o
);

    logic               found;
    logic [31:0]        best_age;
    logic [31:0]        lane_age;
    logic [AL_ID_W-1:0] lane_id;
    logic [AL_ID_W-1:0] best_id;
    logic [PC_W-1:0]    best_pc;

    // Linear scan keeping the strictly-oldest candidate seen so far.
    always_comb begin
        found    = 1'b0;
        best_age = '0;
        lane_age = '0;
        lane_id  = '0;
        best_id  = '0;
        best_pc  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_id  = id_i[i*AL_ID_W +: AL_ID_W];
            lane_age = ageOf(32'(lane_id), 32'(head_i), AL_ID_W);
            if (cand_i[i] && (!found || (lane_age < best_age))) begin
                found    = 1'b1;
                best_age = lane_age;
                best_id  = lane_id;
                best_pc  = pc_i[i*PC_W +: PC_W];
            end
        end
    end

    assign win_valid_o = found;
    assign win_id_o    = best_id;
    assign win_pc_o    = best_pc;

endmodule

// File: rtl/ctrl_redirect_sched.sv
// Collects mispredicts from the control lanes, issues the oldest one
// as a redirect to fetch, then holds a fixed recovery window.
module ctrl_redirect_sched
    import ctrl_redirect_sched_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int AL_ID_W        = CRS_AL_ID_W,
    parameter int PC_W           = CRS_PC_W,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         lane_valid_i,
    input  logic [NUM_LANES-1:0]         lane_mispred_i,
    input  logic [NUM_LANES*AL_ID_W-1:0] lane_alId_i,
    input  logic [NUM_LANES*PC_W-1:0]    lane_nextPC_i,
    input  logic [AL_ID_W-1:0]           alHead_i,
    output logic                         redirect_valid_o,
    input  logic                         redirect_ready_i,
    output logic [PC_W-1:0]              redirect_pc_o,
    output logic [AL_ID_W-1:0]           redirect_alId_o,
    output logic                         recover_o,
    output logic                         stall_ctrl_o
);

    localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

    redirect_state_e    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pvalid_q, pvalid_d;
    logic [AL_ID_W-1:0] pid_q, pid_d;
    logic [PC_W-1:0]    ppc_q, ppc_d;
    logic [AL_ID_W-1:0] rid_q, rid_d;
    logic [PC_W-1:0]    rpc_q, rpc_d;

    logic               win_valid;
    logic [AL_ID_W-1:0] win_id;
    logic [PC_W-1:0]    win_pc;
    logic [31:0]        win_age;
    logic [31:0]        pid_age;
    logic [31:0]        rid_age;
    logic               older_p;
    logic               older_r;
    logic               take;

    ctrl_age_select #(
        .NUM_LANES (NUM_LANES),
        .AL_ID_W   (AL_ID_W),
        .PC_W      (PC_W)
    ) u_sel (
        .cand_i      (lane_valid_i & lane_mispred_i),
        .id_i        (lane_alId_i),
        .pc_i        (lane_nextPC_i),
        .head_i      (alHead_i),
        .win_valid_o (win_valid),
        .win_id_o    (win_id),
        .win_pc_o    (win_pc)
    );

    // Ages are always taken against the live head, stored ids included.
    assign win_age = ageOf(32'(win_id), 32'(alHead_i), AL_ID_W);
    assign pid_age = ageOf(32'(pid_q), 32'(alHead_i), AL_ID_W);
    assign rid_age = ageOf(32'(rid_q), 32'(alHead_i), AL_ID_W);
    assign older_p = win_age < pid_age;
    assign older_r = win_age < rid_age;

    // Next-state: slot capture rules, handshake consume, recovery count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pvalid_d = pvalid_q;
        pid_d    = pid_q;
        ppc_d    = ppc_q;
        rid_d    = rid_q;
        rpc_d    = rpc_q;
        take     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    take    = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                // A winner younger than the offered op would be squashed
                // by its recovery anyway, whether or not it transfers now.
                take = win_valid && older_p;
                if (redirect_ready_i) begin
                    rid_d    = pid_q;
                    rpc_d    = ppc_q;
                    pvalid_d = 1'b0;
                    cnt_d    = CNT_W'(RECOVER_CYCLES);
                    state_d  = RECOVER;
                end
            end
            RECOVER: begin
                take  = win_valid && older_r && (!pvalid_q || older_p);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = (pvalid_q || take) ? PEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            pvalid_d = 1'b1;
            pid_d    = win_id;
            ppc_d    = win_pc;
        end
    end

    // State, slot and recovering-op registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
            pid_q    <= '0;
            ppc_q    <= '0;
            rid_q    <= '0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
            pid_q    <= pid_d;
            ppc_q    <= ppc_d;
            rid_q    <= rid_d;
            rpc_q    <= rpc_d;
        end
    end

    // Outputs decoded from registers only: slot while offering,
    // the accepted op while recovering, zero when idle.
    always_comb begin
        redirect_valid_o = 1'b0;
        recover_o        = 1'b0;
        redirect_pc_o    = '0;
        redirect_alId_o  = '0;
        unique case (state_q)
            PEND: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = ppc_q;
                redirect_alId_o  = pid_q;
            end
            RECOVER: begin
                recover_o       = 1'b1;
                redirect_pc_o   = rpc_q;
                redirect_alId_o = rid_q;
            end
            default: begin
                redirect_valid_o = 1'b0;
            end
        endcase
    end

    assign stall_ctrl_o = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_redirect_sched.sv
// Scoreboard bench for ctrl_redirect_sched: per-cycle predictions from
// a queue-level model, compared by an independent negedge monitor.
module tb_ctrl_redirect_sched;
    import ctrl_redirect_sched_pkg::*;

    localparam int RC = 2;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [6:0]  id;
        logic        rec;
        logic        stall;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  lane_valid_i = '0;
    logic [1:0]  lane_mispred_i = '0;
    logic [13:0] lane_alId_i = '0;
    logic [63:0] lane_nextPC_i = '0;
    logic [6:0]  alHead_i = '0;
    logic        redirect_ready_i = 1'b0;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [6:0]  redirect_alId_o;
    logic        recover_o;
    logic        stall_ctrl_o;

    ctrl_redirect_sched #(
        .NUM_LANES(2), .AL_ID_W(7), .PC_W(32), .RECOVER_CYCLES(RC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lane_valid_i     (lane_valid_i),
        .lane_mispred_i   (lane_mispred_i),
        .lane_alId_i      (lane_alId_i),
        .lane_nextPC_i    (lane_nextPC_i),
        .alHead_i         (alHead_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_alId_o  (redirect_alId_o),
        .recover_o        (recover_o),
        .stall_ctrl_o     (stall_ctrl_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;
    obs_t exp_q[$];
    redirectPkt hs_log[$];

    // Reference model: an optional pending op, the op in recovery and
    // the number of recovery cycles still to run.
    bit         m_pend;
    redirectPkt m_p;
    redirectPkt m_r;
    int         m_rec;

    function automatic int age(input logic [6:0] id, input logic [6:0] hd);
        return (int'(id) - int'(hd) + 128) % 128;
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o.v     = redirect_valid_o;
        o.pc    = redirect_pc_o;
        o.id    = redirect_alId_o;
        o.rec   = recover_o;
        o.stall = stall_ctrl_o;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_p    = '0;
        m_r    = '0;
        m_rec  = 0;
    endtask

    // Monitor: one prediction per cycle, plus a log of accepted redirects.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = cur_obs();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t act=%h req=%h",
                             $time, a, e);
                end
            end
            if (redirect_valid_o && redirect_ready_i)
                hs_log.push_back('{pc: redirect_pc_o, alId: redirect_alId_o});
        end
    end

    // Drive one cycle of inputs, advance the model, queue its prediction.
    task automatic step(input logic [1:0] v, input logic [1:0] m,
                        input logic [6:0] i0, input logic [6:0] i1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [6:0] hd, input logic rdy);
        logic [6:0]  ids[2];
        logic [31:0] pcs[2];
        bit          wv;
        int          wa;
        redirectPkt  w;
        bit          hs;
        bit          cap;
        obs_t        e;
        lane_valid_i     = v;
        lane_mispred_i   = m;
        lane_alId_i      = {i1, i0};
        lane_nextPC_i    = {p1, p0};
        alHead_i         = hd;
        redirect_ready_i = rdy;
        ids[0] = i0; ids[1] = i1;
        pcs[0] = p0; pcs[1] = p1;
        wv = 0; wa = 0; w = '0;
        for (int l = 0; l < 2; l++) begin
            if (v[l] && m[l] && (!wv || age(ids[l], hd) < wa)) begin
                wv = 1;
                wa = age(ids[l], hd);
                w.pc = pcs[l];
                w.alId = ids[l];
            end
        end
        hs  = m_pend && (m_rec == 0) && rdy;
        cap = 0;
        if (m_rec > 0) begin
            cap = wv && (wa < age(m_r.alId, hd)) &&
                  (!m_pend || wa < age(m_p.alId, hd));
            m_rec--;
        end else if (m_pend) begin
            cap = wv && (wa < age(m_p.alId, hd));
            if (hs) begin
                m_r    = m_p;
                m_pend = 0;
                m_rec  = RC;
            end
        end else begin
            cap = wv;
        end
        if (cap) begin
            m_pend = 1;
            m_p    = w;
        end
        e.v   = m_pend && (m_rec == 0);
        e.rec = (m_rec > 0);
        e.stall = e.v || e.rec;
        e.pc  = e.v ? m_p.pc : (e.rec ? m_r.pc : 32'd0);
        e.id  = e.v ? m_p.alId : (e.rec ? m_r.alId : 7'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [6:0] hd, input logic rdy);
        for (int k = 0; k < n; k++)
            step(2'b00, 2'b00, 7'd0, 7'd0, 32'd0, 32'd0, hd, rdy);
    endtask

    // Asynchronous reset mid-operation: outputs must clear before any edge.
    task automatic do_reset(input string nm);
        mon_en = 0;
        reset = 1'b1;
        lane_valid_i = '0;
        lane_mispred_i = '0;
        redirect_ready_i = 1'b0;
        #1;
        chk(nm, 64'(cur_obs()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        mon_en = 1;
    endtask

    task automatic chk_last_hs(input string nm, input int base,
                               input logic [6:0] id, input logic [31:0] pc);
        chk({nm, "_count"}, 64'(hs_log.size()), 64'(base + 1));
        if (hs_log.size() > 0) begin
            chk({nm, "_id"}, 64'(hs_log[hs_log.size()-1].alId), 64'(id));
            chk({nm, "_pc"}, 64'(hs_log[hs_log.size()-1].pc), 64'(pc));
        end
    endtask

    initial begin
        int base;
        logic [6:0] hd;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'(cur_obs()), 64'd0);
        reset = 1'b0;
        exp_q.push_back('0);
        mon_en = 1;

        // Single lane mispredict, ready held high.
        base = hs_log.size();
        step(2'b01, 2'b01, 7'd5, 7'd0, 32'h1000, 32'h0, 7'd0, 1'b1);
        idle(6, 7'd0, 1'b1);
        chk_last_hs("single", base, 7'd5, 32'h1000);

        // Two lanes in one cycle: lane1 is older.
        base = hs_log.size();
        step(2'b11, 2'b11, 7'd9, 7'd4, 32'h2000, 32'h2400, 7'd2, 1'b1);
        idle(6, 7'd2, 1'b1);
        chk_last_hs("two_lane", base, 7'd4, 32'h2400);

        // Wrap-around under backpressure: 127 is older than 1 at head 126.
        base = hs_log.size();
        step(2'b01, 2'b01, 7'd1, 7'd0, 32'h3000, 32'h0, 7'd126, 1'b0);
        step(2'b10, 2'b10, 7'd0, 7'd127, 32'h0, 32'h3f00, 7'd126, 1'b0);
        step(2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 7'd126, 1'b0);
        step(2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 7'd126, 1'b1);
        idle(6, 7'd126, 1'b1);
        chk_last_hs("wrap", base, 7'd127, 32'h3f00);

        // Younger mispredict during recovery is dropped.
        base = hs_log.size();
        step(2'b01, 2'b01, 7'd20, 7'd0, 32'h4000, 32'h0, 7'd0, 1'b1);
        step(2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 7'd0, 1'b1);
        step(2'b01, 2'b01, 7'd30, 7'd0, 32'h4300, 32'h0, 7'd0, 1'b1);
        idle(6, 7'd0, 1'b1);
        chk_last_hs("rec_young", base, 7'd20, 32'h4000);

        // Older mispredict during recovery is issued right after it.
        base = hs_log.size();
        step(2'b01, 2'b01, 7'd20, 7'd0, 32'h5000, 32'h0, 7'd0, 1'b1);
        step(2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 7'd0, 1'b1);
        step(2'b01, 2'b01, 7'd15, 7'd0, 32'h5100, 32'h0, 7'd0, 1'b1);
        idle(8, 7'd0, 1'b1);
        chk("rec_old_count", 64'(hs_log.size()), 64'(base + 2));
        chk_last_hs("rec_old", base + 1, 7'd15, 32'h5100);

        // Reset while offering under backpressure.
        step(2'b01, 2'b01, 7'd3, 7'd0, 32'h6000, 32'h0, 7'd0, 1'b0);
        idle(3, 7'd0, 1'b0);
        do_reset("reset_in_pend");
        idle(5, 7'd0, 1'b1);

        // Valid but never mispredicting: nothing may move.
        for (int k = 0; k < 100; k++)
            step(2'b11, 2'b00, 7'($urandom), 7'($urandom),
                 $urandom, $urandom, 7'($urandom), 1'($urandom));

        // Randomized traffic with head drift, wrap and backpressure.
        hd = 7'd100;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("reset_random");
            end else begin
                if ($urandom_range(0, 199) == 0)
                    hd = 7'(120 + $urandom_range(0, 7));
                else
                    hd = hd + 7'($urandom_range(0, 2));
                step(2'($urandom),
                     {1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0)},
                     hd + 7'($urandom_range(0, 40)),
                     hd + 7'($urandom_range(0, 40)),
                     $urandom, $urandom, hd,
                     1'($urandom_range(0, 2) != 0));
            end
        end
        idle(8, hd, 1'b1);
        mon_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
